tcp_rx_parser: RTL and testbench
================================

Name: tcp_rx_parser

Overview:
- Receive-side TCP header parser directly upstream of tcp_control.
- Consumes a byte stream holding one TCP segment (IP header already stripped) and captures the header fields.
- Filters segments on destination port and forwards payload bytes downstream.
- Emits the one-cycle syn_rcvd / ack_rcvd / fin_rcvd event pulses that drive the tcp_control FSM.

Parameters:
- CNT_W, 16, width of the payload length counter and of the statistics counters.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- local_port  in  16  port this endpoint owns; sampled when a segment starts
- rx_data  in  8  segment byte, network order
- rx_valid  in  1  rx_data valid
- rx_last  in  1  final byte of segment
- rx_ready  out  1  parser accepts byte
- pay_data  out  8  payload byte
- pay_valid  out  1  payload byte valid
- pay_last  out  1  final payload byte
- pay_ready  in  1  downstream accepts payload
- seg_src_port  out  16  remote port of last accepted segment
- seg_seq  out  32  sequence number
- seg_ack  out  32  acknowledgement number
- seg_win  out  16  window
- seg_flags  out  6  {URG,ACK,PSH,RST,SYN,FIN}
- seg_len  out  CNT_W  payload byte count
- syn_rcvd  out  1  pulse: accepted segment had SYN
- ack_rcvd  out  1  pulse: accepted segment had ACK
- fin_rcvd  out  1  pulse: accepted segment had FIN
- rst_rcvd  out  1  pulse: accepted segment had RST
- seg_done  out  1  pulse: segment accepted
- seg_err  out  1  pulse: segment malformed

Behaviour:
- Reset: all outputs 0, rx_ready 0 during reset, FSM to IDLE, counters 0.
- Handshake: a byte transfers when rx_valid && rx_ready. Payload transfers when pay_valid && pay_ready.
- rx_ready = 1 in IDLE, HDR, OPT and DROP; in PAY it equals pay_ready, giving a zero-latency passthrough. pay_data, pay_valid and pay_last are combinational from rx_* in PAY.
- Header bytes (index counted from 0 by a 6-bit counter):
  - 0-1 src_port
  - 2-3 dst_port
  - 4-7 seq
  - 8-11 ack
  - 12[7:4] data offset (DO)
  - 13[5:0] flags
  - 14-15 win
  - 16-19 checksum and urgent pointer, ignored
- Fields are shadow-captured during parsing and copied to the seg_* outputs only on seg_done.
- States:
  - IDLE: the first accepted byte is index 0, go to HDR.
  - HDR: at index 19, if DO<5 or dst_port!=local_port go to DROP (DO<5 marks the segment as an error). Otherwise go to OPT when DO>5, or to PAY when DO==5.
  - OPT: discard bytes until index == DO*4-1, then go to PAY.
  - PAY: forward bytes and increment seg_len. A segment with zero payload never asserts pay_valid.
  - DROP: discard bytes until rx_last.
- End of segment (rx_last accepted), with outputs registered one cycle after the last byte:
  - In PAY: seg_done=1; each flag pulse equals its captured flag bit.
  - In HDR or OPT (runt), or a drop caused by DO<5: seg_err=1, no flag pulses.
  - Port-mismatch drop: no pulses at all.
  - After any end of segment, return to IDLE.
- rx_last on the final header or option byte (no payload) is treated as a PAY end: seg_done, seg_len=0.
- seg_len saturates at all-ones.
- Back-to-back segments are accepted with no idle cycle. The pulses of segment N overlap byte 0 of segment N+1.
- rst_n low mid-segment aborts parsing with no pulses. The next byte after reset release is index 0.

Optional Feature:
- Macro TCP_RX_STATS_EN.
- When defined, adds outputs stat_ok, stat_err and stat_drop (each CNT_W bits, wrapping). They count seg_done, seg_err and port-mismatch drops respectively, and clear on reset.
- When undefined, these ports and counters are absent.

Decomposition:
- Shared package tcp_pkg: FSM state encodings, header byte-index constants (TCP_HDR_MIN=20 etc.) and flag bit positions (FIN=0 … URG=5). tcp_control uses the flag positions too.
- One sub-module, tcp_rx_field_cap: byte-index-driven shift capture of the 16/32-bit fields with a commit strobe.
- FSM, payload path and pulses stay in the top.

Test Plan:
- SYN segment, DO=5, flags=0x02, dst=local_port=80, seq=0x11223344, 20 bytes then last:
  - one-cycle syn_rcvd=1, seg_done=1, seg_seq=0x11223344, seg_len=0, pay_valid never high.
- ACK+FIN with DO=6 (4 option bytes) and 3 payload bytes A1 A2 A3:
  - pay_data A1,A2,A3 with pay_last on A3; ack_rcvd=fin_rcvd=1; seg_len=3.
- Same segment but dst=81:
  - no pulses, no pay_valid, seg_* unchanged, stat_drop+1.
- Runt: rx_last at byte index 9:
  - seg_err=1, no flag pulses, next byte is parsed as index 0.
- pay_ready low for 4 cycles mid-payload:
  - rx_ready low for the same 4 cycles, no byte lost or duplicated.
- rst_n low at header byte 7, then a full SYN segment:
  - only the second segment produces syn_rcvd.

Source files
------------

// File: rtl/tcp_pkg.sv
// tcp_pkg: shared TCP state encodings, header byte indices and flag bit positions.
package tcp_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_HDR, ST_OPT, ST_PAY, ST_DROP} rx_state_t;
    localparam int TCP_HDR_MIN = 20;
    localparam logic [5:0] IDX_SRC      = 6'd0;
    localparam logic [5:0] IDX_DST      = 6'd2;
    localparam logic [5:0] IDX_SEQ      = 6'd4;
    localparam logic [5:0] IDX_ACK      = 6'd8;
    localparam logic [5:0] IDX_DO       = 6'd12;
    localparam logic [5:0] IDX_FLAGS    = 6'd13;
    localparam logic [5:0] IDX_WIN      = 6'd14;
    localparam logic [5:0] IDX_CSUM     = 6'd16;
    localparam logic [5:0] IDX_HDR_LAST = 6'd19;
    localparam int FLAG_FIN = 0;
    localparam int FLAG_SYN = 1;
    localparam int FLAG_RST = 2;
    localparam int FLAG_PSH = 3;
    localparam int FLAG_ACK = 4;
    localparam int FLAG_URG = 5;
    function automatic logic [5:0] hdr_last_idx(input logic [3:0] data_off);
        return {data_off, 2'b00} - 6'd1;
    endfunction
endpackage

// File: rtl/tcp_rx_field_cap.sv
// tcp_rx_field_cap: byte-index-driven shadow capture of TCP header fields, copied out on commit.
module tcp_rx_field_cap
    import tcp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cap_en,
    input  logic [5:0]  idx,
    input  logic [7:0]  rx_byte,
    input  logic        commit,
    output logic [15:0] dst_port,
    output logic [3:0]  data_off,
    output logic [5:0]  flags,
    output logic [15:0] seg_src_port,
    output logic [31:0] seg_seq,
    output logic [31:0] seg_ack,
    output logic [15:0] seg_win,
    output logic [5:0]  seg_flags
);
    logic [15:0] src_sh, win_sh;
    logic [31:0] seq_sh, ack_sh;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {src_sh, dst_port, seq_sh, ack_sh, data_off, flags, win_sh} <= '0;
            {seg_src_port, seg_seq, seg_ack, seg_win, seg_flags} <= '0;
        end else begin
            if (cap_en) begin
                if (idx < IDX_DST) src_sh <= {src_sh[7:0], rx_byte};
                else if (idx < IDX_SEQ) dst_port <= {dst_port[7:0], rx_byte};
                else if (idx < IDX_ACK) seq_sh <= {seq_sh[23:0], rx_byte};
                else if (idx < IDX_DO) ack_sh <= {ack_sh[23:0], rx_byte};
                else if (idx == IDX_DO) data_off <= rx_byte[7:4];
                else if (idx == IDX_FLAGS) flags <= rx_byte[5:0];
                else if (idx < IDX_CSUM) win_sh <= {win_sh[7:0], rx_byte};
            end
            if (commit) begin
                seg_src_port <= src_sh;
                seg_seq      <= seq_sh;
                seg_ack      <= ack_sh;
                seg_win      <= win_sh;
                seg_flags    <= flags;
            end
        end
    end
endmodule

// File: rtl/tcp_rx_parser.sv
// tcp_rx_parser: TCP header parser with port filter, payload passthrough and event pulses.
// Optional statistics counters are enabled with TCP_RX_STATS_EN.
module tcp_rx_parser
    import tcp_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      local_port,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    input  logic             rx_last,
    output logic             rx_ready,
    output logic [7:0]       pay_data,
    output logic             pay_valid,
    output logic             pay_last,
    input  logic             pay_ready,
    output logic [15:0]      seg_src_port,
    output logic [31:0]      seg_seq,
    output logic [31:0]      seg_ack,
    output logic [15:0]      seg_win,
    output logic [5:0]       seg_flags,
    output logic [CNT_W-1:0] seg_len,
    output logic             syn_rcvd,
    output logic             ack_rcvd,
    output logic             fin_rcvd,
    output logic             rst_rcvd,
    output logic             seg_done,
    output logic             seg_err
`ifdef TCP_RX_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_ok,
    output logic [CNT_W-1:0] stat_err,
    output logic [CNT_W-1:0] stat_drop
`endif
);
    rx_state_t state, state_nxt;
    logic [5:0] idx, idx_nxt, cur_idx, last_idx;
    logic [CNT_W-1:0] len_sh, len_nxt, len_inc;
    logic [15:0] lport, dst_sh;
    logic [3:0] do_sh;
    logic [5:0] flags_sh;
    logic acc, done, err, drop, drop_err, drop_err_nxt, do_bad, port_bad;
    assign rx_ready  = rst_n && (state != ST_PAY || pay_ready);
    assign acc       = rx_valid && rx_ready;
    assign cur_idx   = state == ST_IDLE ? 6'd0 : idx;
    assign pay_valid = rst_n && state == ST_PAY && rx_valid;
    assign pay_data  = pay_valid ? rx_data : 8'h00;
    assign pay_last  = pay_valid && rx_last;
    assign len_inc   = &len_sh ? len_sh : len_sh + CNT_W'(1);
    assign do_bad    = do_sh < 4'd5;
    assign port_bad  = dst_sh != lport;
    assign last_idx  = hdr_last_idx(do_sh);
    tcp_rx_field_cap u_cap (
        .clk(clk), .rst_n(rst_n),
        .cap_en(acc && (state == ST_IDLE || state == ST_HDR)),
        .idx(cur_idx), .rx_byte(rx_data), .commit(done),
        .dst_port(dst_sh), .data_off(do_sh), .flags(flags_sh),
        .seg_src_port(seg_src_port), .seg_seq(seg_seq), .seg_ack(seg_ack),
        .seg_win(seg_win), .seg_flags(seg_flags)
    );
    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        len_nxt      = len_sh;
        drop_err_nxt = drop_err;
        done         = 1'b0;
        err          = 1'b0;
        drop         = 1'b0;
        if (acc) begin
            idx_nxt = cur_idx + 6'd1;
            case (state)
                ST_IDLE, ST_HDR: begin
                    if (cur_idx == IDX_HDR_LAST) begin
                        // a malformed data offset outranks the port filter and reports as an error
                        drop_err_nxt = do_bad;
                        state_nxt = (do_bad || port_bad) ? ST_DROP : do_sh > 4'd5 ? ST_OPT : ST_PAY;
                        done = rx_last && !do_bad && !port_bad && do_sh == 4'd5;
                        err  = rx_last && (do_bad || (!port_bad && do_sh > 4'd5));
                        drop = rx_last && !do_bad && port_bad;
                    end else begin
                        state_nxt = ST_HDR;
                        err = rx_last;
                    end
                end
                ST_OPT: begin
                    state_nxt = cur_idx == last_idx ? ST_PAY : ST_OPT;
                    done = rx_last && cur_idx == last_idx;
                    err  = rx_last && cur_idx != last_idx;
                end
                ST_PAY: begin
                    len_nxt = len_inc;
                    done = rx_last;
                end
                ST_DROP: begin
                    err  = rx_last && drop_err;
                    drop = rx_last && !drop_err;
                end
                default: state_nxt = ST_IDLE;
            endcase
            if (rx_last) begin
                state_nxt = ST_IDLE;
                idx_nxt   = 6'd0;
                len_nxt   = '0;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            idx      <= '0;
            len_sh   <= '0;
            drop_err <= 1'b0;
            lport    <= '0;
            seg_len  <= '0;
            {syn_rcvd, ack_rcvd, fin_rcvd, rst_rcvd, seg_done, seg_err} <= '0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            len_sh   <= len_nxt;
            drop_err <= drop_err_nxt;
            if (acc && state == ST_IDLE) lport <= local_port;
            if (done) seg_len <= state == ST_PAY ? len_inc : len_sh;
            syn_rcvd <= done && flags_sh[FLAG_SYN];
            ack_rcvd <= done && flags_sh[FLAG_ACK];
            fin_rcvd <= done && flags_sh[FLAG_FIN];
            rst_rcvd <= done && flags_sh[FLAG_RST];
            seg_done <= done;
            seg_err  <= err;
        end
    end
`ifdef TCP_RX_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {stat_ok, stat_err, stat_drop} <= '0;
        end else begin
            if (done) stat_ok <= stat_ok + CNT_W'(1);
            if (err) stat_err <= stat_err + CNT_W'(1);
            if (drop) stat_drop <= stat_drop + CNT_W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_tcp_rx_parser.sv
// tb_tcp_rx_parser: directed segments checked each cycle against a per-segment outcome model.
module tb_tcp_rx_parser;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n, rx_valid, rx_last, rx_ready, pay_valid, pay_last, pay_ready;
    logic [15:0] local_port, seg_src_port, seg_win, seg_len;
    logic [7:0] rx_data, pay_data;
    logic [31:0] seg_seq, seg_ack;
    logic [5:0] seg_flags;
    logic syn_rcvd, ack_rcvd, fin_rcvd, rst_rcvd, seg_done, seg_err;
`ifdef TCP_RX_STATS_EN
    logic [15:0] stat_ok, stat_err, stat_drop;
`endif
    tcp_rx_parser #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .local_port(local_port),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_last(rx_last), .rx_ready(rx_ready),
        .pay_data(pay_data), .pay_valid(pay_valid), .pay_last(pay_last), .pay_ready(pay_ready),
        .seg_src_port(seg_src_port), .seg_seq(seg_seq), .seg_ack(seg_ack), .seg_win(seg_win),
        .seg_flags(seg_flags), .seg_len(seg_len),
        .syn_rcvd(syn_rcvd), .ack_rcvd(ack_rcvd), .fin_rcvd(fin_rcvd), .rst_rcvd(rst_rcvd),
        .seg_done(seg_done), .seg_err(seg_err)
`ifdef TCP_RX_STATS_EN
        , .stat_ok(stat_ok), .stat_err(stat_err), .stat_drop(stat_drop)
`endif
    );
    // kind: 0 nothing, 1 accepted, 2 malformed, 3 filtered by port
    typedef struct packed {
        logic [1:0]  kind;
        logic [5:0]  flags;
        logic [15:0] src;
        logic [31:0] seq;
        logic [31:0] ack;
        logic [15:0] win;
        logic [15:0] len;
    } res_t;
    int checks = 0, errors = 0;
    logic [7:0] seg [64];
    int seg_n, m_hl, pos;
    bit m_acc, prev_rst;
    res_t m_res, pend;
    logic [117:0] exp_f;
    int syn_cnt, ack_cnt, fin_cnt, done_cnt, err_cnt, stalls, exp_ok, exp_err, exp_drop;
    logic [7:0] pay_got [$];
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask
    task automatic model();
        logic [3:0] d;
        d = seg[12][7:4];
        m_hl = int'(d) * 4;
        m_acc = seg_n >= 20 && d >= 4'd5 && {seg[2], seg[3]} == local_port;
        m_res = '0;
        if (seg_n < 20 || d < 4'd5) m_res.kind = 2'd2;
        else if ({seg[2], seg[3]} != local_port) m_res.kind = 2'd3;
        else if (seg_n < m_hl) m_res.kind = 2'd2;
        else begin
            m_res.kind  = 2'd1;
            m_res.flags = seg[13][5:0];
            m_res.src   = {seg[0], seg[1]};
            m_res.seq   = {seg[4], seg[5], seg[6], seg[7]};
            m_res.ack   = {seg[8], seg[9], seg[10], seg[11]};
            m_res.win   = {seg[14], seg[15]};
            m_res.len   = 16'(seg_n - m_hl);
        end
    endtask
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ready", {rx_ready, pay_valid}, 2'b00);
            if (prev_rst)
                chk("rst_outputs", {syn_rcvd, ack_rcvd, fin_rcvd, rst_rcvd, seg_done, seg_err,
                    seg_src_port, seg_seq, seg_ack, seg_win, seg_flags, seg_len}, 0);
            pend = '0;
            pos = 0;
            exp_f = '0;
            {exp_ok, exp_err, exp_drop} = '0;
            prev_rst = 1'b1;
        end else begin
            bit in_pay;
            prev_rst = 1'b0;
            chk("pulses", {syn_rcvd, ack_rcvd, fin_rcvd, rst_rcvd, seg_done, seg_err},
                pend.kind == 2'd1 ? {pend.flags[1], pend.flags[4], pend.flags[0], pend.flags[2], 2'b10} :
                pend.kind == 2'd2 ? 6'b000001 : 6'b000000);
            if (pend.kind == 2'd1) begin
                exp_f = {pend.src, pend.seq, pend.ack, pend.win, pend.flags, pend.len};
                exp_ok++;
            end
            if (pend.kind == 2'd2) exp_err++;
            if (pend.kind == 2'd3) exp_drop++;
            chk("seg_fields", {seg_src_port, seg_seq, seg_ack, seg_win, seg_flags, seg_len}, exp_f);
`ifdef TCP_RX_STATS_EN
            chk("stats", {stat_ok, stat_err, stat_drop}, {16'(exp_ok), 16'(exp_err), 16'(exp_drop)});
`endif
            in_pay = m_acc && pos >= m_hl;
            chk("rx_ready", rx_ready, in_pay ? pay_ready : 1'b1);
            chk("pay_valid", pay_valid, in_pay && rx_valid);
            if (in_pay && rx_valid) chk("pay_data", {pay_data, pay_last}, {rx_data, rx_last});
            syn_cnt  += int'(syn_rcvd);
            ack_cnt  += int'(ack_rcvd);
            fin_cnt  += int'(fin_rcvd);
            done_cnt += int'(seg_done);
            err_cnt  += int'(seg_err);
            if (rx_valid && !rx_ready) stalls++;
            if (pay_valid && pay_ready) pay_got.push_back(pay_data);
            pend = '0;
            if (rx_valid && rx_ready) begin
                if (rx_last) begin
                    pend = m_res;
                    pos = 0;
                end else pos++;
            end
        end
    end
    task automatic hdr(input logic [15:0] src, input logic [15:0] dst, input logic [31:0] sq,
                       input logic [31:0] ak, input logic [3:0] d, input logic [5:0] fl, input logic [15:0] w);
        {seg[0], seg[1], seg[2], seg[3]} = {src, dst};
        {seg[4], seg[5], seg[6], seg[7]} = sq;
        {seg[8], seg[9], seg[10], seg[11]} = ak;
        seg[12] = {d, 4'h0};
        seg[13] = {2'b00, fl};
        {seg[14], seg[15]} = w;
        {seg[16], seg[17], seg[18], seg[19]} = 32'hC5C5_0000;
        for (int i = 20; i < int'(d) * 4; i++) seg[i] = 8'h01;
        seg_n = d < 4'd5 ? 20 : int'(d) * 4;
    endtask
    task automatic add(input logic [7:0] b);
        seg[seg_n] = b;
        seg_n++;
    endtask
    task automatic idle(input int n);
        rx_valid = 1'b0;
        rx_last = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic send(input int stall_i, input int rst_i);
        model();
        for (int i = 0; i < seg_n; i++) begin
            bit ok;
            int t;
            rx_data = seg[i];
            rx_valid = 1'b1;
            rx_last = i == seg_n - 1;
            if (i == rst_i) begin
                rx_valid = 1'b0;
                rx_last = 1'b0;
                rst_n = 1'b0;
                repeat (3) @(posedge clk);
                #1 rst_n = 1'b1;
                return;
            end
            if (i == stall_i) begin
                pay_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 pay_ready = 1'b1;
            end
            ok = 1'b0;
            t = 0;
            while (!ok) begin
                @(negedge clk);
                ok = rx_ready;
                @(posedge clk);
                #1;
                if (++t > 50) begin
                    chk("handshake_timeout", 1'b1, 1'b0);
                    rx_valid = 1'b0;
                    return;
                end
            end
        end
    endtask
    function automatic logic [63:0] got_vec();
        logic [63:0] v = '0;
        for (int i = 0; i < pay_got.size(); i++) v = {v[55:0], pay_got[i]};
        return v;
    endfunction
    initial begin
        rst_n = 1'b0;
        rx_valid = 1'b0;
        rx_last = 1'b0;
        rx_data = 8'h00;
        pay_ready = 1'b1;
        local_port = 16'd80;
        seg_n = 0;
        m_res = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);
        chk("idle_ready", rx_ready, 1'b1);
        // plain SYN, no options, no payload
        hdr(16'h1234, 16'd80, 32'h11223344, 32'h0, 4'd5, 6'h02, 16'h4000);
        send(-1, -1);
        idle(3);
        chk("t1_seq", seg_seq, 32'h11223344);
        chk("t1_len", seg_len, 16'd0);
        chk("t1_syn", syn_cnt, 1);
        chk("t1_pay", pay_got.size(), 0);
        // ACK+FIN with one option word and 3 payload bytes
        hdr(16'h1234, 16'd80, 32'h55, 32'hAABBCCDD, 4'd6, 6'h11, 16'h2000);
        add(8'hA1); add(8'hA2); add(8'hA3);
        send(-1, -1);
        idle(3);
        chk("t2_len", seg_len, 16'd3);
        chk("t2_ack_fin", {ack_cnt, fin_cnt}, {32'd1, 32'd1});
        chk("t2_pay", {pay_got.size(), got_vec()}, {32'd3, 64'hA1A2A3});
        // same segment to another port
        pay_got.delete();
        seg[3] = 8'd81;
        send(-1, -1);
        idle(3);
        chk("t3_pay", pay_got.size(), 0);
        chk("t3_keep", {seg_seq, seg_len}, {32'h55, 16'd3});
        chk("t3_done", done_cnt, 2);
        // runt at index 9, then a SYN back-to-back
        hdr(16'h1234, 16'd80, 32'h66, 32'h0, 4'd5, 6'h02, 16'h1000);
        seg_n = 10;
        send(-1, -1);
        hdr(16'h4321, 16'd80, 32'h99, 32'h0, 4'd5, 6'h02, 16'h1000);
        send(-1, -1);
        idle(3);
        chk("t4_err", err_cnt, 1);
        chk("t4_seq", {seg_src_port, seg_seq}, {16'h4321, 32'h99});
        chk("t4_cnt", {done_cnt, syn_cnt}, {32'd3, 32'd2});
        // downstream backpressure mid-payload
        pay_got.delete();
        stalls = 0;
        hdr(16'h0007, 16'd80, 32'h5555, 32'h1, 4'd5, 6'h18, 16'h0100);
        for (int b = 16; b < 24; b++) add(8'(b));
        send(23, -1);
        idle(3);
        chk("t5_stalls", stalls, 4);
        chk("t5_pay", {pay_got.size(), got_vec()}, {32'd8, 64'h1011121314151617});
        chk("t5_len", seg_len, 16'd8);
        // reset at header byte 7, then a full SYN
        hdr(16'h1234, 16'd80, 32'h1, 32'h0, 4'd5, 6'h02, 16'h1000);
        send(-1, 7);
        idle(1);
        hdr(16'h1234, 16'd80, 32'h77, 32'h0, 4'd5, 6'h02, 16'h1000);
        send(-1, -1);
        idle(3);
        chk("t6_syn", syn_cnt, 3);
        chk("t6_seq", seg_seq, 32'h77);
        chk("t6_done", done_cnt, 5);
        // data offset below 5 is malformed even with payload behind it
        hdr(16'h1234, 16'd80, 32'h88, 32'h0, 4'd4, 6'h12, 16'h1000);
        for (int b = 0; b < 6; b++) add(8'hEE);
        send(-1, -1);
        idle(3);
        chk("t7_err", {err_cnt, done_cnt}, {32'd2, 32'd5});
        chk("t7_keep", seg_seq, 32'h77);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
